// File: rtl/weight_fetch_arbiter.sv
// Round-robin arbiter that fetches 512-bit weight lines from host memory for
// the RDN and DNN engines, with one outstanding memory read at a time.
module weight_fetch_arbiter (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fetch_start,
  input  logic [31:0]      rdn_base_addr,
  input  logic [31:0]      dnn_base_addr,
  input  logic [15:0]      rdn_num_lines,
  input  logic [15:0]      dnn_num_lines,
  input  logic             rdn_mem_req,
  input  logic             dnn_mem_req,
  output logic             mem_rd_req,
  output logic [31:0]      mem_rd_addr,
  input  logic             mem_rd_rdy,
  input  logic             mem_rd_vld,
  input  logic [511:0]     mem_rd_data,
  output logic             rdn_load_weights,
  output logic             dnn_load_weights,
  output logic             weight_mem_ready,
  output logic [7:0][63:0] rdn_weight_data,
  output logic [7:0][63:0] dnn_weight_data,
  output logic             rdn_done,
  output logic             dnn_done
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDeliver} state_e;

  state_e       state_q, state_d;
  logic [31:0]  rdn_base_q, rdn_base_d, dnn_base_q, dnn_base_d;
  logic [31:0]  addr_q, addr_d;
  logic [15:0]  rdn_num_q, rdn_num_d, dnn_num_q, dnn_num_d;
  logic [15:0]  rdn_cnt_q, rdn_cnt_d, dnn_cnt_q, dnn_cnt_d;
  logic         rdn_done_q, rdn_done_d, dnn_done_q, dnn_done_d;
  logic         last_dnn_q, last_dnn_d;
  logic         gnt_dnn_q, gnt_dnn_d;
  logic [511:0] rdn_data_q, rdn_data_d, dnn_data_q, dnn_data_d;

  logic         rdn_elig, dnn_elig, pick_dnn;
  logic [15:0]  rdn_cnt_inc, dnn_cnt_inc;

  assign rdn_elig    = rdn_mem_req & ~rdn_done_q;
  assign dnn_elig    = dnn_mem_req & ~dnn_done_q;
  // On a tie, grant whichever side was not granted last.
  assign pick_dnn    = dnn_elig & (~rdn_elig | ~last_dnn_q);
  assign rdn_cnt_inc = rdn_cnt_q + 16'd1;
  assign dnn_cnt_inc = dnn_cnt_q + 16'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (!fetch_start && (rdn_elig || dnn_elig)) begin
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (mem_rd_rdy) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (mem_rd_vld) begin
          state_d = StDeliver;
        end
      end
      StDeliver: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    rdn_base_d = rdn_base_q;
    dnn_base_d = dnn_base_q;
    rdn_num_d  = rdn_num_q;
    dnn_num_d  = dnn_num_q;
    rdn_cnt_d  = rdn_cnt_q;
    dnn_cnt_d  = dnn_cnt_q;
    rdn_done_d = rdn_done_q;
    dnn_done_d = dnn_done_q;
    last_dnn_d = last_dnn_q;
    gnt_dnn_d  = gnt_dnn_q;
    addr_d     = addr_q;
    rdn_data_d = rdn_data_q;
    dnn_data_d = dnn_data_q;
    unique case (state_q)
      StIdle: begin
        if (fetch_start) begin
          rdn_base_d = rdn_base_addr;
          dnn_base_d = dnn_base_addr;
          rdn_num_d  = rdn_num_lines;
          dnn_num_d  = dnn_num_lines;
          rdn_cnt_d  = '0;
          dnn_cnt_d  = '0;
          rdn_done_d = (rdn_num_lines == 16'd0);
          dnn_done_d = (dnn_num_lines == 16'd0);
        end else if (rdn_elig || dnn_elig) begin
          gnt_dnn_d  = pick_dnn;
          last_dnn_d = pick_dnn;
          addr_d     = pick_dnn ? dnn_base_q + {10'd0, dnn_cnt_q, 6'd0}
                                : rdn_base_q + {10'd0, rdn_cnt_q, 6'd0};
        end
      end
      StWait: begin
        if (mem_rd_vld) begin
          if (gnt_dnn_q) begin
            dnn_data_d = mem_rd_data;
          end else begin
            rdn_data_d = mem_rd_data;
          end
        end
      end
      StDeliver: begin
        if (gnt_dnn_q) begin
          dnn_cnt_d  = dnn_cnt_inc;
          dnn_done_d = (dnn_cnt_inc == dnn_num_q);
        end else begin
          rdn_cnt_d  = rdn_cnt_inc;
          rdn_done_d = (rdn_cnt_inc == rdn_num_q);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdn_base_q <= '0;
      dnn_base_q <= '0;
      rdn_num_q  <= '0;
      dnn_num_q  <= '0;
      rdn_cnt_q  <= '0;
      dnn_cnt_q  <= '0;
      rdn_done_q <= 1'b0;
      dnn_done_q <= 1'b0;
      last_dnn_q <= 1'b1;
      gnt_dnn_q  <= 1'b0;
      addr_q     <= '0;
      rdn_data_q <= '0;
      dnn_data_q <= '0;
    end else begin
      rdn_base_q <= rdn_base_d;
      dnn_base_q <= dnn_base_d;
      rdn_num_q  <= rdn_num_d;
      dnn_num_q  <= dnn_num_d;
      rdn_cnt_q  <= rdn_cnt_d;
      dnn_cnt_q  <= dnn_cnt_d;
      rdn_done_q <= rdn_done_d;
      dnn_done_q <= dnn_done_d;
      last_dnn_q <= last_dnn_d;
      gnt_dnn_q  <= gnt_dnn_d;
      addr_q     <= addr_d;
      rdn_data_q <= rdn_data_d;
      dnn_data_q <= dnn_data_d;
    end
  end

  always_comb begin
    mem_rd_req       = (state_q == StIssue);
    rdn_load_weights = (state_q == StDeliver) && !gnt_dnn_q;
    dnn_load_weights = (state_q == StDeliver) && gnt_dnn_q;
    weight_mem_ready = (state_q == StDeliver);
  end

  assign mem_rd_addr     = addr_q;
  assign rdn_weight_data = rdn_data_q;
  assign dnn_weight_data = dnn_data_q;
  assign rdn_done        = rdn_done_q;
  assign dnn_done        = dnn_done_q;

endmodule

// File: doc/weight_fetch_arbiter.md
WEIGHT_FETCH_ARBITER -- requirements
Module: weight_fetch_arbiter

Interface
REQ-001 clk  input  1  sole clock, all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 fetch_start  input  1  one-cycle pulse: clear both line counters, begin new weight load.
REQ-004 rdn_base_addr / dnn_base_addr  input  32 each  byte base address of RDN / DNN weight image, sampled on accepted fetch_start.
REQ-005 rdn_num_lines / dnn_num_lines  input  16 each  512-bit lines in each image, sampled on accepted fetch_start.
REQ-006 rdn_mem_req / dnn_mem_req  input  1 each  level request for the next weight line; held until matching load pulse.
REQ-007 mem_rd_req  output  1  read request to host memory port.
REQ-008 mem_rd_addr  output  32  byte address of requested line, 64-byte aligned.
REQ-009 mem_rd_rdy  input  1  memory accepts request when mem_rd_req && mem_rd_rdy.
REQ-010 mem_rd_vld / mem_rd_data  input  1 / 512  read return; one return per accepted request, in order.
REQ-011 rdn_load_weights / dnn_load_weights  output  1 each  one-cycle pulse: line delivered to that requester.
REQ-012 weight_mem_ready  output  1  high in the delivery cycle.
REQ-013 rdn_weight_data / dnn_weight_data  output  8 x 64  delivered line; word i = mem_rd_data[64i+63:64i].
REQ-014 rdn_done / dnn_done  output  1 each  level: that image fully fetched.

Function
REQ-015 FSM states: IDLE, ISSUE, WAIT, DELIVER; one outstanding memory read at a time.
REQ-016 IDLE: fetch_start has priority; when asserted, capture bases/counts, clear counters, clear done flags (done set immediately if its num_lines = 0), stay IDLE that cycle.
REQ-017 IDLE, no start: eligible requester = req high and not done; none eligible -> stay IDLE.
REQ-018 Both eligible: round-robin, grant the one not granted last; last_grant resets to DNN so RDN wins first tie.
REQ-019 Grant -> ISSUE; mem_rd_addr = base + line_cnt*64 (mod 2^32) of granted requester, held stable while in ISSUE.
REQ-020 ISSUE: mem_rd_req = 1; on mem_rd_rdy -> WAIT; else remain ISSUE with request and address unchanged.
REQ-021 WAIT: on mem_rd_vld capture mem_rd_data into granted requester's data register -> DELIVER.
REQ-022 DELIVER (exactly one cycle): pulse granted load_weights and weight_mem_ready; increment its line_cnt; set done when incremented count equals num_lines; -> IDLE.
REQ-023 Data registers hold last delivered line until overwritten; non-granted register unchanged.
REQ-024 Requests from a done requester are ignored; no memory traffic issued.
REQ-025 fetch_start outside IDLE is ignored (no latch).
REQ-026 mem_rd_vld outside WAIT is ignored.
REQ-027 Latency: request seen in IDLE at cycle N, mem_rd_rdy=1 and data returned k cycles after acceptance -> load pulse at cycle N+2+k (k >= 1).
REQ-028 line_cnt 16-bit, never exceeds num_lines.

Reset
REQ-029 rst_n low, any state: FSM -> IDLE; mem_rd_req, load pulses, weight_mem_ready = 0; mem_rd_addr = 0; counters, bases, counts = 0; data registers = 0; last_grant = DNN; rdn_done = dnn_done = 0.
REQ-030 Reset mid-transaction abandons outstanding read; a subsequent mem_rd_vld is discarded (FSM in IDLE).

Verification
REQ-031 Start rdn_base=0x1000, rdn_num_lines=2, hold rdn_mem_req -> addresses 0x1000, 0x1040; two rdn_load_weights pulses; rdn_done high after second; no third read.
REQ-032 Both reqs high continuously, counts=4 each -> grant order RDN, DNN, RDN, DNN, ...; each load pulse paired with correct data.
REQ-033 mem_rd_rdy low 5 cycles in ISSUE -> mem_rd_req and mem_rd_addr stable for 6 cycles, single acceptance.
REQ-034 mem_rd_data word i = i+1 pattern -> rdn_weight_data[i] = i+1; dnn_weight_data unchanged.
REQ-035 rst_n low during WAIT, mem_rd_vld arrives after release -> no load pulse, all outputs at reset values.
REQ-036 fetch_start during WAIT -> ignored, counters unaffected; dnn_num_lines=0 start -> dnn_done high next cycle, dnn_mem_req produces no read.
